// File: rtl/riscvi_pkg.sv
// Shared RISC-VI pipeline definitions: funct3 codes, writeback sources,
// ValidReg bit positions, MEM-stage FSM encoding and an alignment helper.
package riscvi_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] REGSRC_ALU   = 2'd0;
  localparam logic [1:0] REGSRC_LOAD  = 2'd1;
  localparam logic [1:0] REGSRC_PCIMM = 2'd2;
  localparam logic [1:0] REGSRC_PC4   = 2'd3;

  localparam int VR_WRITE_RD = 0;
  localparam int VR_USE_RS1  = 1;
  localparam int VR_USE_RS2  = 2;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_WAIT = 1'b1
  } lsu_state_e;

  // size is funct3[1:0]: 00 byte, 01 halfword, otherwise word
  function automatic logic is_aligned(input logic [1:0] addr_lo, input logic [1:0] size);
    case (size)
      2'b00:   return 1'b1;
      2'b01:   return ~addr_lo[0];
      default: return (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Load lane select and sign/zero extension of a 32-bit read word.
// Latency: combinational. Backpressure: none.
module load_extract
  import riscvi_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      F3_LH:   data = {{16{half_lane[15]}}, half_lane};
      F3_LBU:  data = {24'h0, byte_lane};
      F3_LHU:  data = {16'h0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM stage: drives the data-memory port, aligns loads, owns the MEM/WB register.
// Latency 1 cycle MEM->WB plus one per not-ready cycle; stalls upstream while memory is busy.
module load_store_unit
  import riscvi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_ALU_result,
  input  logic [31:0] MEM_rs2_data,
  input  logic [31:0] MEM_pc,
  input  logic [31:0] MEM_pc_eximm,
  input  logic [2:0]  MEM_funct3,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [1:0]  MEM_RegSrc,
  input  logic [4:0]  MEM_rd,
  input  logic [2:0]  MEM_ValidReg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] WB_rd_write_data,
  output logic [4:0]  WB_rd,
  output logic [2:0]  WB_ValidReg,
  output logic        mem_misaligned,
  output logic [31:0] mem_fault_addr
);

  lsu_state_e  state_q, state_d;
  logic        req_we_q, req_we_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_be_q, req_be_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [2:0]  wb_vr_q, wb_vr_d;
  logic        mis_q, mis_d;
  logic [31:0] fault_q, fault_d;

  logic        access;
  logic        aligned;
  logic [31:0] new_wdata;
  logic [3:0]  new_be;
  logic [31:0] load_data;
  logic [31:0] wb_mux;

  assign access  = (MEM_ValidReg != 3'b000) && (MEM_MemRead || MEM_MemWrite);
  assign aligned = is_aligned(MEM_ALU_result[1:0], MEM_funct3[1:0]);

  load_extract u_load_extract (
    .rdata   (dmem_rdata),
    .addr_lo (MEM_ALU_result[1:0]),
    .funct3  (MEM_funct3),
    .data    (load_data)
  );

  always_comb begin
    new_wdata = 32'h0;
    new_be    = 4'b1111;
    if (MEM_MemWrite) begin
      case (MEM_funct3[1:0])
        2'b00: begin
          new_wdata = {4{MEM_rs2_data[7:0]}};
          new_be    = 4'b0001 << MEM_ALU_result[1:0];
        end
        2'b01: begin
          new_wdata = {2{MEM_rs2_data[15:0]}};
          new_be    = 4'b0011 << MEM_ALU_result[1:0];
        end
        default: begin
          new_wdata = MEM_rs2_data;
          new_be    = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    case (MEM_RegSrc)
      REGSRC_ALU:   wb_mux = MEM_ALU_result;
      REGSRC_LOAD:  wb_mux = load_data;
      REGSRC_PCIMM: wb_mux = MEM_pc_eximm;
      default:      wb_mux = MEM_pc + 32'd4;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_vr_d     = wb_vr_q;
    mis_d       = 1'b0;
    fault_d     = fault_q;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    dmem_addr   = 32'h0;
    dmem_wdata  = 32'h0;
    dmem_be     = 4'h0;

    if (!rst) begin
      case (state_q)
        LSU_IDLE: begin
          if (access && aligned) begin
            dmem_req   = 1'b1;
            dmem_we    = MEM_MemWrite;
            dmem_addr  = {MEM_ALU_result[31:2], 2'b00};
            dmem_wdata = new_wdata;
            dmem_be    = new_be;
            if (!dmem_ready) begin
              state_d     = LSU_WAIT;
              req_we_d    = dmem_we;
              req_addr_d  = dmem_addr;
              req_wdata_d = dmem_wdata;
              req_be_d    = dmem_be;
            end
          end
        end
        default: begin
          // Replay the captured request so the port is stable for the whole wait.
          dmem_req   = 1'b1;
          dmem_we    = req_we_q;
          dmem_addr  = req_addr_q;
          dmem_wdata = req_wdata_q;
          dmem_be    = req_be_q;
          if (dmem_ready) begin
            state_d = LSU_IDLE;
          end
        end
      endcase
    end

    mem_stall = dmem_req & ~dmem_ready;

    if (mem_stall) begin
      wb_vr_d = 3'b000;
    end else if (access && !aligned) begin
      wb_vr_d = 3'b000;
      mis_d   = 1'b1;
      fault_d = MEM_ALU_result;
    end else begin
      wb_data_d = wb_mux;
      wb_rd_d   = MEM_rd;
      wb_vr_d   = MEM_ValidReg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LSU_IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= 32'h0;
      req_wdata_q <= 32'h0;
      req_be_q    <= 4'h0;
      wb_data_q   <= 32'h0;
      wb_rd_q     <= 5'h0;
      wb_vr_q     <= 3'h0;
      mis_q       <= 1'b0;
      fault_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_be_q    <= req_be_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_vr_q     <= wb_vr_d;
      mis_q       <= mis_d;
      fault_q     <= fault_d;
    end
  end

  assign WB_rd_write_data = wb_data_q;
  assign WB_rd            = wb_rd_q;
  assign WB_ValidReg      = wb_vr_q;
  assign mem_misaligned   = mis_q;
  assign mem_fault_addr   = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed MEM-stage vectors push expected
// WB results; a negedge monitor pops and compares whenever WB presents something.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] MEM_ALU_result, MEM_rs2_data, MEM_pc, MEM_pc_eximm;
  logic [2:0]  MEM_funct3;
  logic        MEM_MemRead, MEM_MemWrite;
  logic [1:0]  MEM_RegSrc;
  logic [4:0]  MEM_rd;
  logic [2:0]  MEM_ValidReg;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] WB_rd_write_data;
  logic [4:0]  WB_rd;
  logic [2:0]  WB_ValidReg;
  logic        mem_misaligned;
  logic [31:0] mem_fault_addr;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .MEM_ALU_result(MEM_ALU_result), .MEM_rs2_data(MEM_rs2_data),
    .MEM_pc(MEM_pc), .MEM_pc_eximm(MEM_pc_eximm), .MEM_funct3(MEM_funct3),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_RegSrc(MEM_RegSrc),
    .MEM_rd(MEM_rd), .MEM_ValidReg(MEM_ValidReg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .WB_rd_write_data(WB_rd_write_data), .WB_rd(WB_rd), .WB_ValidReg(WB_ValidReg),
    .mem_misaligned(mem_misaligned), .mem_fault_addr(mem_fault_addr)
  );

  typedef struct packed {
    logic        mis;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [2:0]  vr;
    logic [31:0] faddr;
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc,
                       input logic [31:0] pcimm, input logic [2:0] f3, input logic rd_en,
                       input logic wr_en, input logic [1:0] src, input logic [4:0] rd,
                       input logic [2:0] vr);
    MEM_ALU_result = alu;
    MEM_rs2_data   = rs2;
    MEM_pc         = pc;
    MEM_pc_eximm   = pcimm;
    MEM_funct3     = f3;
    MEM_MemRead    = rd_en;
    MEM_MemWrite   = wr_en;
    MEM_RegSrc     = src;
    MEM_rd         = rd;
    MEM_ValidReg   = vr;
  endtask

  task automatic nop();
    issue(32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 2'd0, 5'd0, 3'b000);
  endtask

  task automatic push_wb(input logic [31:0] data, input logic [4:0] rd, input logic [2:0] vr);
    exp_t e;
    e = '{mis: 1'b0, data: data, rd: rd, vr: vr, faddr: 32'h0};
    sb_q.push_back(e);
  endtask

  task automatic push_fault(input logic [31:0] addr);
    exp_t e;
    e = '{mis: 1'b1, data: 32'h0, rd: 5'd0, vr: 3'b000, faddr: addr};
    sb_q.push_back(e);
  endtask

  // Monitor: any visible WB result or fault pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (WB_ValidReg != 3'b000 || mem_misaligned)) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_wb: vr=%0d mis=%0d data=0x%08h, expected no output",
                 WB_ValidReg, mem_misaligned, WB_rd_write_data);
      end else begin
        e = sb_q.pop_front();
        chk("wb_misaligned", {31'h0, mem_misaligned}, {31'h0, e.mis});
        chk("wb_validreg", {29'h0, WB_ValidReg}, {29'h0, e.vr});
        if (e.mis) begin
          chk("fault_addr", mem_fault_addr, e.faddr);
        end else begin
          chk("wb_data", WB_rd_write_data, e.data);
          chk("wb_rd", {27'h0, WB_rd}, {27'h0, e.rd});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    issue(32'h3000, 32'h0, 32'h0, 32'h0, 3'b010, 1'b1, 1'b0, 2'd1, 5'd7, 3'b001);
    tick();
    tick();
    @(negedge clk);
    chk("rst_wb_data", WB_rd_write_data, 32'h0);
    chk("rst_wb_rd", {27'h0, WB_rd}, 32'h0);
    chk("rst_wb_vr", {29'h0, WB_ValidReg}, 32'h0);
    chk("rst_mis", {31'h0, mem_misaligned}, 32'h0);
    chk("rst_fault_addr", mem_fault_addr, 32'h0);
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_stall", {31'h0, mem_stall}, 32'h0);
    tick();
    rst = 1'b0;
    nop();
    tick();

    // LB at 0x1003 with immediate ready: byte 0x80 sign-extends
    issue(32'h1003, 32'h0, 32'h0, 32'h0, 3'b000, 1'b1, 1'b0, 2'd1, 5'd5, 3'b001);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h80FF1234;
    push_wb(32'hFFFFFF80, 5'd5, 3'b001);
    @(negedge clk);
    chk("lb_req", {31'h0, dmem_req}, 32'h1);
    chk("lb_we", {31'h0, dmem_we}, 32'h0);
    chk("lb_addr", dmem_addr, 32'h1000);
    chk("lb_be", {28'h0, dmem_be}, 32'hF);
    chk("lb_stall", {31'h0, mem_stall}, 32'h0);
    tick();

    // LHU at 0x1002: upper half 0x80FF zero-extended
    issue(32'h1002, 32'h0, 32'h0, 32'h0, 3'b101, 1'b1, 1'b0, 2'd1, 5'd12, 3'b011);
    push_wb(32'h000080FF, 5'd12, 3'b011);
    tick();
    // LH at 0x1000: 0xF234 sign-extended
    issue(32'h1000, 32'h0, 32'h0, 32'h0, 3'b001, 1'b1, 1'b0, 2'd1, 5'd13, 3'b001);
    dmem_rdata = 32'h0000F234;
    push_wb(32'hFFFFF234, 5'd13, 3'b001);
    tick();
    // LBU at 0x1001: byte 0x12
    issue(32'h1001, 32'h0, 32'h0, 32'h0, 3'b100, 1'b1, 1'b0, 2'd1, 5'd14, 3'b001);
    dmem_rdata = 32'h80FF1234;
    push_wb(32'h00000012, 5'd14, 3'b001);
    tick();

    // SH at 0x2002
    issue(32'h2002, 32'h0000ABCD, 32'h0, 32'h0, 3'b001, 1'b0, 1'b1, 2'd0, 5'd0, 3'b110);
    push_wb(32'h2002, 5'd0, 3'b110);
    @(negedge clk);
    chk("sh_req", {31'h0, dmem_req}, 32'h1);
    chk("sh_we", {31'h0, dmem_we}, 32'h1);
    chk("sh_addr", dmem_addr, 32'h2000);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh_be", {28'h0, dmem_be}, 32'hC);
    tick();

    // SB at 0x2001
    issue(32'h2001, 32'h12345678, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, 2'd0, 5'd0, 3'b110);
    push_wb(32'h2001, 5'd0, 3'b110);
    @(negedge clk);
    chk("sb_wdata", dmem_wdata, 32'h78787878);
    chk("sb_be", {28'h0, dmem_be}, 32'h2);
    tick();

    // LW at 0x3000 with three not-ready cycles
    issue(32'h3000, 32'h0, 32'h0, 32'h0, 3'b010, 1'b1, 1'b0, 2'd1, 5'd7, 3'b001);
    dmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dmem_rdata = 32'h11111111 * (k + 1);
      @(negedge clk);
      chk("lw_wait_stall", {31'h0, mem_stall}, 32'h1);
      chk("lw_wait_req", {31'h0, dmem_req}, 32'h1);
      chk("lw_wait_addr", dmem_addr, 32'h3000);
      chk("lw_wait_be", {28'h0, dmem_be}, 32'hF);
      chk("lw_wait_we", {31'h0, dmem_we}, 32'h0);
      if (k > 0) chk("lw_wait_wb_bubble", {29'h0, WB_ValidReg}, 32'h0);
      tick();
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    push_wb(32'hDEADBEEF, 5'd7, 3'b001);
    @(negedge clk);
    chk("lw_done_stall", {31'h0, mem_stall}, 32'h0);
    chk("lw_done_req", {31'h0, dmem_req}, 32'h1);
    tick();
    nop();
    dmem_ready = 1'b0;
    tick();

    // Misaligned LW at 0x4002: no request, one-cycle fault pulse
    issue(32'h4002, 32'h0, 32'h0, 32'h0, 3'b010, 1'b1, 1'b0, 2'd1, 5'd8, 3'b001);
    push_fault(32'h4002);
    @(negedge clk);
    chk("mis_req", {31'h0, dmem_req}, 32'h0);
    chk("mis_stall", {31'h0, mem_stall}, 32'h0);
    tick();
    nop();
    tick();
    @(negedge clk);
    chk("mis_pulse_end", {31'h0, mem_misaligned}, 32'h0);
    tick();

    // Back-to-back faults: LH at 0x5001 then SW at 0x5002
    issue(32'h5001, 32'h0, 32'h0, 32'h0, 3'b001, 1'b1, 1'b0, 2'd1, 5'd9, 3'b001);
    push_fault(32'h5001);
    tick();
    issue(32'h5002, 32'hCAFEF00D, 32'h0, 32'h0, 3'b010, 1'b0, 1'b1, 2'd0, 5'd0, 3'b110);
    push_fault(32'h5002);
    tick();
    nop();
    tick();
    @(negedge clk);
    chk("mis_pair_end", {31'h0, mem_misaligned}, 32'h0);
    tick();

    // PC+4 wraps; PC+imm passes through
    issue(32'h1234, 32'h0, 32'hFFFFFFFC, 32'h0, 3'b000, 1'b0, 1'b0, 2'd3, 5'd9, 3'b001);
    push_wb(32'h00000000, 5'd9, 3'b001);
    tick();
    issue(32'h1234, 32'h0, 32'h100, 32'h12345678, 3'b000, 1'b0, 1'b0, 2'd2, 5'd10, 3'b011);
    push_wb(32'h12345678, 5'd10, 3'b011);
    @(negedge clk);
    chk("nonmem_req", {31'h0, dmem_req}, 32'h0);
    tick();

    // MemRead with ValidReg=0: no request, bubble only
    issue(32'h7000, 32'h0, 32'h0, 32'h0, 3'b010, 1'b1, 1'b0, 2'd1, 5'd15, 3'b000);
    dmem_ready = 1'b1;
    @(negedge clk);
    chk("vr0_req", {31'h0, dmem_req}, 32'h0);
    tick();
    nop();
    dmem_ready = 1'b0;
    tick();

    // Reset while in WAIT
    issue(32'h6000, 32'h0, 32'h0, 32'h0, 3'b010, 1'b1, 1'b0, 2'd1, 5'd11, 3'b001);
    @(negedge clk);
    chk("rw_stall", {31'h0, mem_stall}, 32'h1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rw_req_in_rst", {31'h0, dmem_req}, 32'h0);
    chk("rw_stall_in_rst", {31'h0, mem_stall}, 32'h0);
    tick();
    rst = 1'b0;
    nop();
    dmem_ready = 1'b1;
    dmem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("rw_req_after", {31'h0, dmem_req}, 32'h0);
    chk("rw_wb_data", WB_rd_write_data, 32'h0);
    chk("rw_wb_rd", {27'h0, WB_rd}, 32'h0);
    chk("rw_wb_vr", {29'h0, WB_ValidReg}, 32'h0);
    chk("rw_mis", {31'h0, mem_misaligned}, 32'h0);
    tick();
    @(negedge clk);
    chk("rw_stray_ready_vr", {29'h0, WB_ValidReg}, 32'h0);
    chk("rw_stray_ready_data", WB_rd_write_data, 32'h0);
    dmem_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
